// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: ALU op codes, status-register
// bit positions, reset value of P and the sequencer state type.
package alu_sequencer_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_SR  = 3'd4;

  localparam int unsigned CARRY = 0;
  localparam int unsigned ZERO  = 1;
  localparam int unsigned INT   = 2;
  localparam int unsigned DEC   = 3;
  localparam int unsigned BRK   = 4;
  localparam int unsigned OVF   = 6;
  localparam int unsigned NEG   = 7;

  localparam logic [7:0] P_RESET = 8'h34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ADJ  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // Which P bits an ALU op is allowed to overwrite; unknown codes touch nothing.
  function automatic logic [7:0] flag_mask(input logic [2:0] op);
    logic [7:0] m;
    m = 8'h00;
    case (op)
      OP_ADD: begin
        m[NEG]   = 1'b1;
        m[OVF]   = 1'b1;
        m[ZERO]  = 1'b1;
        m[CARRY] = 1'b1;
      end
      OP_OR, OP_XOR, OP_AND: begin
        m[NEG]  = 1'b1;
        m[ZERO] = 1'b1;
      end
      OP_SR: begin
        m[NEG]   = 1'b1;
        m[ZERO]  = 1'b1;
        m[CARRY] = 1'b1;
      end
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_sequencer_decimal_adjust.sv
// BCD correction term for a decimal ADD: from the operand low nibbles, the
// carry-in and the 9-bit binary sum it produces the value to add in a second
// ALU pass, plus the decimal carry out.
module decimal_adjust (
  input  logic [3:0] a_lo_i,
  input  logic [3:0] b_lo_i,
  input  logic       cin_i,
  input  logic [8:0] sum_i,
  output logic [7:0] corr_o,
  output logic       carry_o
);

  logic [4:0] low_sum;

  // Low nibble over 9 needs +6; whole sum over 99 needs +60 and sets carry.
  always_comb begin
    low_sum = {1'b0, a_lo_i} + {1'b0, b_lo_i} + {4'd0, cin_i};
    carry_o = (sum_i > 9'h099);
    corr_o  = 8'h00;
    if (low_sum > 5'd9) begin
      corr_o = corr_o | 8'h06;
    end
    if (carry_o) begin
      corr_o = corr_o | 8'h60;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle driver for the combinational 6502 ALU and owner of the status
// register P. Ops run IDLE -> EXEC -> (ADJ for decimal ADD) -> DONE, with P
// written on the edge that enters DONE. Flag strobes and PLP loads are taken
// in every state.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [2:0] alu_ctrl,
  output logic [7:0] alu_AI,
  output logic [7:0] alu_BI,
  output logic       alu_carry,
  output logic       alu_BCD,
  input  logic [7:0] alu_Y,
  input  logic [7:0] alu_flags,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] p_reg,
  input  logic       p_load,
  input  logic [7:0] p_load_data,
  input  logic       p_set_c,
  input  logic       p_clr_c,
  input  logic       p_set_d,
  input  logic       p_clr_d,
  input  logic       p_set_i,
  input  logic       p_clr_i,
  input  logic       p_clr_v
);

  seq_state_e state_q;
  logic [2:0] alu_ctrl_q;
  logic [7:0] alu_ai_q;
  logic [7:0] alu_bi_q;
  logic       alu_carry_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       bin_v_q;
  logic       dec_c_q;
  logic [7:0] p_q;
  logic [7:0] p_d;

  logic [7:0] corr;
  logic       dec_c;
  logic       bin_v;
  logic       dec_mode;
  logic       wb_en;
  logic       wb_c;
  logic       wb_v;
  logic [7:0] wb_mask;
  logic [7:0] wb_flags;
  logic       unused_flags;

  // Only the carry bit of the ALU flag bus is meaningful here.
  assign unused_flags = ^alu_flags[7:1];

  assign req_ready = (state_q == ST_IDLE);
  assign alu_ctrl  = alu_ctrl_q;
  assign alu_AI    = alu_ai_q;
  assign alu_BI    = alu_bi_q;
  assign alu_carry = alu_carry_q;
  assign alu_BCD   = 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign p_reg     = p_q;

  // Overflow always comes from the binary pass, which is what EXEC sees.
  assign bin_v    = (alu_ai_q[7] == alu_bi_q[7]) && (alu_Y[7] != alu_ai_q[7]);
  assign dec_mode = (alu_ctrl_q == OP_ADD) && p_q[DEC];

  decimal_adjust u_decimal_adjust (
    .a_lo_i  (alu_ai_q[3:0]),
    .b_lo_i  (alu_bi_q[3:0]),
    .cin_i   (alu_carry_q),
    .sum_i   ({alu_flags[CARRY], alu_Y}),
    .corr_o  (corr),
    .carry_o (dec_c)
  );

  // Flag values and write mask for the edge that enters DONE.
  always_comb begin
    wb_en = 1'b0;
    wb_c  = alu_flags[CARRY];
    wb_v  = bin_v;
    case (state_q)
      ST_EXEC: wb_en = !dec_mode;
      ST_ADJ: begin
        wb_en = 1'b1;
        wb_c  = dec_c_q;
        wb_v  = bin_v_q;
      end
      default: wb_en = 1'b0;
    endcase
    wb_flags        = 8'h00;
    wb_flags[NEG]   = alu_Y[7];
    wb_flags[OVF]   = wb_v;
    wb_flags[ZERO]  = (alu_Y == 8'h00);
    wb_flags[CARRY] = wb_c;
    wb_mask = wb_en ? flag_mask(alu_ctrl_q) : 8'h00;
  end

  // Next P: clear strobes lose to set strobes, which lose to ALU writeback,
  // and a PLP load overrides everything; bits 5 and 4 are hardwired high.
  always_comb begin
    p_d = p_q;
    if (p_clr_c) p_d[CARRY] = 1'b0;
    if (p_clr_d) p_d[DEC]   = 1'b0;
    if (p_clr_i) p_d[INT]   = 1'b0;
    if (p_clr_v) p_d[OVF]   = 1'b0;
    if (p_set_c) p_d[CARRY] = 1'b1;
    if (p_set_d) p_d[DEC]   = 1'b1;
    if (p_set_i) p_d[INT]   = 1'b1;
    p_d = (p_d & ~wb_mask) | (wb_flags & wb_mask);
    if (p_load) p_d = p_load_data;
    p_d[5]   = 1'b1;
    p_d[BRK] = 1'b1;
  end

  // Status register.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= P_RESET;
    end else begin
      p_q <= p_d;
    end
  end

  // Sequencer FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      alu_ctrl_q  <= 3'd0;
      alu_ai_q    <= 8'h00;
      alu_bi_q    <= 8'h00;
      alu_carry_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      bin_v_q     <= 1'b0;
      dec_c_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            alu_ctrl_q  <= req_op;
            alu_ai_q    <= req_a;
            alu_bi_q    <= req_b;
            alu_carry_q <= p_q[CARRY];
            state_q     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          bin_v_q <= bin_v;
          if (dec_mode) begin
            alu_ctrl_q  <= OP_ADD;
            alu_ai_q    <= alu_Y;
            alu_bi_q    <= corr;
            alu_carry_q <= 1'b0;
            dec_c_q     <= dec_c;
            state_q     <= ST_ADJ;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_Y;
            state_q     <= ST_DONE;
          end
        end
        ST_ADJ: begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= alu_Y;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU environment, a
// transaction-level reference model of the sequencer and P register, a
// per-cycle compare process, directed scenarios with hand-computed values,
// and a randomized phase.
module tb_alu_sequencer;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [2:0] alu_ctrl;
  logic [7:0] alu_AI;
  logic [7:0] alu_BI;
  logic       alu_carry;
  logic       alu_BCD;
  logic [7:0] alu_Y;
  logic [7:0] alu_flags;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] p_reg;
  logic       p_load;
  logic [7:0] p_load_data;
  logic       p_set_c, p_clr_c, p_set_d, p_clr_d, p_set_i, p_clr_i, p_clr_v;

  int nChecks = 0;
  int nFails  = 0;

  alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_ctrl    (alu_ctrl),
    .alu_AI      (alu_AI),
    .alu_BI      (alu_BI),
    .alu_carry   (alu_carry),
    .alu_BCD     (alu_BCD),
    .alu_Y       (alu_Y),
    .alu_flags   (alu_flags),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .p_reg       (p_reg),
    .p_load      (p_load),
    .p_load_data (p_load_data),
    .p_set_c     (p_set_c),
    .p_clr_c     (p_clr_c),
    .p_set_d     (p_set_d),
    .p_clr_d     (p_clr_d),
    .p_set_i     (p_set_i),
    .p_clr_i     (p_clr_i),
    .p_clr_v     (p_clr_v)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: returns {carry, Y}. Logic ops report an inverted carry-in
  // so a sequencer that wrongly writes C for them gets caught.
  function automatic logic [8:0] aluFn(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic c);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b} + {8'd0, c};
      3'd1:    return {~c, a | b};
      3'd2:    return {~c, a ^ b};
      3'd3:    return {~c, a & b};
      3'd4:    return {a[0], c, a[7:1]};
      default: return {1'b1, a ^ 8'h5A};
    endcase
  endfunction

  // Flags each op may change: ADD NVZC, logic NZ, SR NZC, others none.
  function automatic logic [7:0] affected(input logic [2:0] op);
    case (op)
      3'd0:             return 8'hC3;
      3'd1, 3'd2, 3'd3: return 8'h82;
      3'd4:             return 8'h83;
      default:          return 8'h00;
    endcase
  endfunction

  // The ALU the DUT talks to is purely combinational; upper flag bits are noise.
  logic [8:0] aluOut;
  always_comb begin
    aluOut    = aluFn(alu_ctrl, alu_AI, alu_BI, alu_carry);
    alu_Y     = aluOut[7:0];
    alu_flags = {~aluOut[6:0], aluOut[8]};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model state, advanced once per rising edge from the inputs.
  int         cyc = 0;
  bit         mInit = 0;
  logic [7:0] mP;
  bit         busy = 0;
  int         accCyc, rspCyc;
  logic [2:0] mOp;
  logic [7:0] mA, mB;
  logic       mCin;
  bit         isDec = 0;
  logic [7:0] pendMask, pendVal;
  logic [7:0] expRsp, adjY, adjCorr;
  int         acceptCount = 0;
  bit         expReady, expRspValid, expAluValid;
  logic [2:0] expCtrl;
  logic [7:0] expAI, expBI;
  logic       expCarry;

  // Model: an accepted op completes one cycle after EXEC (two for decimal
  // ADD), P takes strobe/load/writeback priorities bit by bit.
  always @(posedge clk) begin : model
    logic [7:0] np, wbMask, wbVal, corr, res, flags;
    logic [8:0] bin, sumS;
    logic [4:0] lowSum;
    logic       c, v;
    bit         wasIdle;
    cyc++;
    if (reset) begin
      mInit = 1;
      mP    = 8'h34;
      busy  = 0;
    end else if (mInit) begin
      wbMask  = 8'h00;
      wbVal   = 8'h00;
      wasIdle = !busy;
      if (busy && cyc == accCyc + 1) begin
        bin = aluFn(mOp, mA, mB, mCin);
        v   = (mA[7] == mB[7]) && (bin[7] != mA[7]);
        if (mOp == 3'd0 && mP[3]) begin
          lowSum  = {1'b0, mA[3:0]} + {1'b0, mB[3:0]} + {4'd0, mCin};
          sumS    = {1'b0, mA} + {1'b0, mB} + {8'd0, mCin};
          corr    = ((lowSum > 5'd9) ? 8'h06 : 8'h00) | ((sumS > 9'h099) ? 8'h60 : 8'h00);
          res     = bin[7:0] + corr;
          c       = (sumS > 9'h099);
          isDec   = 1;
          adjY    = bin[7:0];
          adjCorr = corr;
          rspCyc  = cyc + 1;
        end else begin
          res    = bin[7:0];
          c      = bin[8];
          isDec  = 0;
          rspCyc = cyc;
        end
        flags  = {res[7], v, 4'b0000, (res == 8'h00), c};
        expRsp = res;
        if (isDec) begin
          pendMask = affected(mOp);
          pendVal  = flags;
        end else begin
          wbMask = affected(mOp);
          wbVal  = flags;
        end
      end else if (busy && isDec && cyc == accCyc + 2) begin
        wbMask = pendMask;
        wbVal  = pendVal;
      end
      if (busy && cyc == rspCyc + 1) busy = 0;
      np = mP;
      if (p_clr_c) np[0] = 1'b0;
      if (p_clr_d) np[3] = 1'b0;
      if (p_clr_i) np[2] = 1'b0;
      if (p_clr_v) np[6] = 1'b0;
      if (p_set_c) np[0] = 1'b1;
      if (p_set_d) np[3] = 1'b1;
      if (p_set_i) np[2] = 1'b1;
      np = (np & ~wbMask) | (wbVal & wbMask);
      if (p_load) np = p_load_data;
      np[5] = 1'b1;
      np[4] = 1'b1;
      if (wasIdle && req_valid) begin
        busy   = 1;
        accCyc = cyc;
        mOp    = req_op;
        mA     = req_a;
        mB     = req_b;
        mCin   = mP[0];
        isDec  = 0;
        rspCyc = cyc + 1000;
        acceptCount++;
      end
      mP = np;
    end
    expReady    = !busy;
    expRspValid = busy && (cyc == rspCyc);
    expAluValid = 0;
    if (busy && cyc == accCyc) begin
      expAluValid = 1;
      expCtrl = mOp; expAI = mA; expBI = mB; expCarry = mCin;
    end else if (busy && isDec && cyc == accCyc + 1) begin
      expAluValid = 1;
      expCtrl = 3'd0; expAI = adjY; expBI = adjCorr; expCarry = 1'b0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mInit) begin
      checkOutput("p_reg", p_reg, mP);
      checkOutput("req_ready", req_ready, expReady);
      checkOutput("rsp_valid", rsp_valid, expRspValid);
      if (expRspValid) checkOutput("rsp_data", rsp_data, expRsp);
      checkOutput("alu_BCD", alu_BCD, 0);
      if (expAluValid) begin
        checkOutput("alu_ctrl", alu_ctrl, expCtrl);
        checkOutput("alu_AI", alu_AI, expAI);
        checkOutput("alu_BI", alu_BI, expBI);
        checkOutput("alu_carry", alu_carry, expCarry);
      end
    end
  end

  // Present a request at a falling edge and hold it until the model accepts;
  // returns at the falling edge inside the EXEC cycle.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int start;
    start     = acceptCount;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acceptCount != start) break;
    end
    if (acceptCount == start) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL accept_timeout: request op=%0d not taken within 20 cycles", op);
    end
    req_valid = 1'b0;
  endtask

  task automatic clearStrobes();
    {p_set_c, p_clr_c, p_set_d, p_clr_d, p_set_i, p_clr_i, p_clr_v, p_load} = '0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (expReady) break;
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    int raiseAcc;
    reset = 1'b1;
    req_valid = 1'b0; req_op = 3'd0; req_a = 8'h00; req_b = 8'h00;
    p_load_data = 8'h00;
    clearStrobes();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_p_reg", p_reg, 8'h34);
    checkOutput("reset_ready", req_ready, 1);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_data", rsp_data, 8'h00);
    checkOutput("reset_alu_ctrl", alu_ctrl, 3'd0);
    checkOutput("reset_alu_AI", alu_AI, 8'h00);
    checkOutput("reset_alu_BI", alu_BI, 8'h00);
    checkOutput("reset_alu_carry", alu_carry, 0);
    reset = 1'b0;
    @(negedge clk);

    // Binary ADD 50+50 with C=0, D=0.
    applyStimulus(3'd0, 8'h50, 8'h50);
    checkOutput("bin_exec_no_rsp", rsp_valid, 0);
    @(negedge clk);
    checkOutput("bin_rsp_valid", rsp_valid, 1);
    checkOutput("bin_rsp_data", rsp_data, 8'hA0);
    checkOutput("bin_NVZC", {p_reg[7], p_reg[6], p_reg[1], p_reg[0]}, 4'b1100);
    @(negedge clk);

    // Decimal ADD 58+46 with D=1, C=0.
    p_set_d = 1'b1; p_clr_c = 1'b1;
    @(negedge clk);
    clearStrobes();
    applyStimulus(3'd0, 8'h58, 8'h46);
    checkOutput("dec_exec_no_rsp", rsp_valid, 0);
    @(negedge clk);
    checkOutput("dec_adj_BI", alu_BI, 8'h66);
    checkOutput("dec_adj_AI", alu_AI, 8'h9E);
    checkOutput("dec_adj_no_rsp", rsp_valid, 0);
    @(negedge clk);
    checkOutput("dec_rsp_valid", rsp_valid, 1);
    checkOutput("dec_rsp_data", rsp_data, 8'h04);
    checkOutput("dec_ZC", {p_reg[1], p_reg[0]}, 2'b01);
    p_clr_d = 1'b1;
    @(negedge clk);
    clearStrobes();

    // AND with C=1, and a second request held while busy.
    applyStimulus(3'd3, 8'hF0, 8'h0F);
    req_valid = 1'b1; req_op = 3'd0; req_a = 8'h11; req_b = 8'h22;
    @(negedge clk);
    checkOutput("and_rsp_data", rsp_data, 8'h00);
    checkOutput("and_NZC", {p_reg[7], p_reg[1], p_reg[0]}, 3'b011);
    checkOutput("and_busy_not_ready", req_ready, 0);
    applyStimulus(3'd0, 8'h11, 8'h22);
    @(negedge clk);
    checkOutput("held_add_rsp_data", rsp_data, 8'h34);
    waitIdle();

    // Collision of set strobes with ADD writeback.
    p_clr_c = 1'b1; p_clr_i = 1'b1;
    @(negedge clk);
    clearStrobes();
    applyStimulus(3'd0, 8'h01, 8'h01);
    p_set_c = 1'b1; p_set_i = 1'b1;
    @(negedge clk);
    clearStrobes();
    checkOutput("coll_rsp_data", rsp_data, 8'h02);
    checkOutput("coll_C", p_reg[0], 0);
    checkOutput("coll_I", p_reg[2], 1);
    waitIdle();

    // Reset during EXEC.
    p_set_c = 1'b1; p_clr_i = 1'b1;
    @(negedge clk);
    clearStrobes();
    applyStimulus(3'd0, 8'h33, 8'h44);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_mid_p_reg", p_reg, 8'h34);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_mid_no_rsp", rsp_valid, 0);
      checkOutput("rst_mid_ready", req_ready, 1);
    end

    // Randomized traffic; requests are held until the model accepts them.
    raiseAcc = acceptCount;
    for (int n = 0; n < 600; n++) begin
      if (!(req_valid && acceptCount == raiseAcc)) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_op    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        req_a     = 8'($urandom_range(0, 255));
        req_b     = 8'($urandom_range(0, 255));
        raiseAcc  = acceptCount;
      end
      p_set_c = ($urandom_range(0, 11) == 0);
      p_clr_c = ($urandom_range(0, 11) == 0);
      p_set_d = ($urandom_range(0, 5) == 0);
      p_clr_d = ($urandom_range(0, 5) == 0);
      p_set_i = ($urandom_range(0, 11) == 0);
      p_clr_i = ($urandom_range(0, 11) == 0);
      p_clr_v = ($urandom_range(0, 11) == 0);
      p_load  = ($urandom_range(0, 31) == 0);
      p_load_data = 8'($urandom_range(0, 255));
      reset   = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    req_valid = 1'b0;
    clearStrobes();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
